// File: rtl/mux_n_stream_if.sv
// mux_n_stream_if: N-channel valid/ready input bundle plus tagged registered output stream.
interface mux_n_stream_if #(parameter int WIDTH = 16, parameter int N_CH = 4);
  localparam int SEL_W = $clog2(N_CH);
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;
  modport master (output in_data, in_valid, mode, sel, out_ready,
                  input  in_ready, out_data, out_ch, out_valid);
  modport slave  (input  in_data, in_valid, mode, sel, out_ready,
                  output in_ready, out_data, out_ch, out_valid);
endinterface

// File: rtl/mux_n_stream.sv
// mux_n_stream: N-channel stream mux, fixed select or round-robin with burst locking, registered output.
module mux_n_stream #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4,
  parameter int BURST = 1
) (
  input logic           clk,
  input logic           rst_n,
  mux_n_stream_if.slave b
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(BURST + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx, lg, lg_nx, grant;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [N_CH-1:0]  rdy;
  logic             has_grant, can_load, xfer;
  assign b.in_ready = rdy;
  always_comb begin
    can_load  = !b.out_valid || b.out_ready;
    grant     = '0;
    has_grant = 1'b0;
    if (state == LOCK) begin
      grant     = lg;
      has_grant = 1'b1;
    end else if (!b.mode) begin
      grant     = b.sel;
      has_grant = int'(b.sel) < N_CH;
    end else begin
      // descending scan so the nearest valid channel at or after ptr wins
      for (int i = N_CH - 1; i >= 0; i--)
        if (b.in_valid[(int'(ptr) + i) % N_CH]) begin
          grant     = SEL_W'((int'(ptr) + i) % N_CH);
          has_grant = 1'b1;
        end
    end
    rdy      = (has_grant && can_load && rst_n) ? N_CH'(1) << grant : '0;
    xfer     = |(b.in_valid & rdy);
    state_nx = state;
    ptr_nx   = ptr;
    lg_nx    = lg;
    cnt_nx   = cnt;
    if (xfer && state == LOCK) begin
      cnt_nx = cnt + CNT_W'(1);
      if (cnt_nx == CNT_W'(BURST)) begin
        state_nx = IDLE;
        cnt_nx   = '0;
        ptr_nx   = SEL_W'((int'(lg) + 1) % N_CH);
      end
    end else if (xfer && b.mode) begin
      if (BURST == 1) ptr_nx = SEL_W'((int'(grant) + 1) % N_CH);
      else begin
        state_nx = LOCK;
        lg_nx    = grant;
        cnt_nx   = CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      lg          <= '0;
      cnt         <= '0;
      b.out_valid <= 1'b0;
      b.out_data  <= '0;
      b.out_ch    <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      lg    <= lg_nx;
      cnt   <= cnt_nx;
      if (xfer) begin
        b.out_valid <= 1'b1;
        b.out_data  <= b.in_data[int'(grant)*WIDTH +: WIDTH];
        b.out_ch    <= grant;
      end else if (b.out_ready) b.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_n_stream.sv
// tb_mux_n_stream: directed + random checks of two mux instances (4ch/burst 1, 5ch/burst 3) against a behavioural model.
module tb_mux_n_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_n_stream_if #(.WIDTH(16), .N_CH(4)) a_if ();
  mux_n_stream_if #(.WIDTH(16), .N_CH(5)) b_if ();
  mux_n_stream #(.WIDTH(16), .N_CH(4), .BURST(1)) dut_a (.clk(clk), .rst_n(rst_n), .b(a_if));
  mux_n_stream #(.WIDTH(16), .N_CH(5), .BURST(3)) dut_b (.clk(clk), .rst_n(rst_n), .b(b_if));
  logic [79:0] din  [2];
  logic [4:0]  vld  [2];
  logic        md   [2];
  logic [2:0]  sl   [2];
  logic        ordy [2];
  logic [4:0]  rdy_o [2];
  logic        ov_o  [2];
  logic [15:0] od_o  [2];
  logic [2:0]  och_o [2];
  assign a_if.in_data   = din[0][63:0];
  assign a_if.in_valid  = vld[0][3:0];
  assign a_if.mode      = md[0];
  assign a_if.sel       = sl[0][1:0];
  assign a_if.out_ready = ordy[0];
  assign b_if.in_data   = din[1];
  assign b_if.in_valid  = vld[1];
  assign b_if.mode      = md[1];
  assign b_if.sel       = sl[1];
  assign b_if.out_ready = ordy[1];
  assign rdy_o[0] = {1'b0, a_if.in_ready};
  assign rdy_o[1] = b_if.in_ready;
  assign ov_o[0]  = a_if.out_valid;
  assign ov_o[1]  = b_if.out_valid;
  assign od_o[0]  = a_if.out_data;
  assign od_o[1]  = b_if.out_data;
  assign och_o[0] = {1'b0, a_if.out_ch};
  assign och_o[1] = b_if.out_ch;
  int n_chk = 0;
  int n_fail = 0;
  int          m_ptr [2], m_lg [2], m_cnt [2], m_och [2], m_x [2];
  bit          m_lock [2], m_ov [2];
  logic [15:0] m_od [2];
  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask
  task automatic mreset(int d);
    m_ptr[d] = 0; m_lg[d] = 0; m_cnt[d] = 0; m_och[d] = 0; m_x[d] = -1;
    m_lock[d] = 0; m_ov[d] = 0; m_od[d] = '0;
  endtask
  function automatic int grant_of(int d);
    int n = d ? 5 : 4;
    if (m_lock[d]) return m_lg[d];
    if (!md[d]) return (int'(sl[d]) < n) ? int'(sl[d]) : -1;
    for (int i = 0; i < n; i++)
      if (vld[d][(m_ptr[d] + i) % n]) return (m_ptr[d] + i) % n;
    return -1;
  endfunction
  // called before the edge: checks present outputs, then advances the model across that edge
  task automatic model_step(int d);
    int n = d ? 5 : 4;
    int bu = d ? 3 : 1;
    int g = grant_of(d);
    bit cl = !m_ov[d] || ordy[d];
    logic [4:0] er = (g >= 0 && cl) ? (5'b1 << g) : 5'b0;
    bit xfer = g >= 0 && cl && vld[d][g];
    chk("in_ready", d, 32'(rdy_o[d]), 32'(er));
    chk("out_valid", d, 32'(ov_o[d]), 32'(m_ov[d]));
    chk("out_data", d, 32'(od_o[d]), 32'(m_od[d]));
    chk("out_ch", d, 32'(och_o[d]), 32'(m_och[d]));
    m_x[d] = xfer ? g : -1;
    if (xfer) begin
      m_ov[d] = 1; m_od[d] = din[d][g*16 +: 16]; m_och[d] = g;
    end else if (ordy[d]) m_ov[d] = 0;
    if (xfer && m_lock[d]) begin
      m_cnt[d]++;
      if (m_cnt[d] == bu) begin m_lock[d] = 0; m_ptr[d] = (m_lg[d] + 1) % n; end
    end else if (xfer && md[d]) begin
      if (bu == 1) m_ptr[d] = (g + 1) % n;
      else begin m_lock[d] = 1; m_lg[d] = g; m_cnt[d] = 1; end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp3 [7] = '{1, 1, 1, 3, 3, 3, 1};
    int exp3b [5] = '{1, 1, 3, 3, 3};
    for (int d = 0; d < 2; d++) begin
      din[d] = '0; vld[d] = '0; md[d] = 0; sl[d] = '0; ordy[d] = 1; mreset(d);
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, 32'(ov_o[d]), 0);
      chk("rst_out_data", d, 32'(od_o[d]), 0);
      chk("rst_out_ch", d, 32'(och_o[d]), 0);
      chk("rst_in_ready", d, 32'(rdy_o[d]), 0);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    // fixed select of channel 2 with every channel offering data
    for (int k = 0; k < 4; k++) din[0][k*16 +: 16] = 16'(16'hA000 + k);
    din[0][47:32] = 16'h1234;
    sl[0] = 3'd2; vld[0] = 5'b01111;
    tick();
    chk("t1_out_data", 0, 32'(od_o[0]), 32'h1234);
    chk("t1_out_ch", 0, 32'(och_o[0]), 2);
    chk("t1_out_valid", 0, 32'(ov_o[0]), 1);
    vld[0] = '0;
    tick();
    // round-robin burst 1, all valid
    md[0] = 1; vld[0] = 5'b01111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_out_ch", 0, 32'(och_o[0]), 32'(i % 4));
      chk("t2_out_valid", 0, 32'(ov_o[0]), 1);
    end
    vld[0] = '0;
    tick();
    // round-robin burst 3 on channels 1 and 3
    for (int k = 0; k < 5; k++) din[1][k*16 +: 16] = 16'(16'hB000 + k);
    md[1] = 1; vld[1] = 5'b01010;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_out_ch", 1, 32'(och_o[1]), 32'(exp3[i]));
    end
    vld[1] = 5'b01000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_hold_valid", 1, 32'(ov_o[1]), 0);
    end
    vld[1] = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_resume_ch", 1, 32'(och_o[1]), 32'(exp3b[i]));
    end
    vld[1] = '0;
    tick();
    // backpressure on the burst-1 instance
    vld[0] = 5'b01111;
    tick();
    ordy[0] = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_held_data", 0, 32'(od_o[0]), 32'h0000A000);
      chk("t4_held_valid", 0, 32'(ov_o[0]), 1);
      chk("t4_in_ready", 0, 32'(rdy_o[0]), 0);
    end
    ordy[0] = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_resume_ch", 0, 32'(och_o[0]), 32'((i + 1) % 4));
    end
    vld[0] = '0;
    tick();
    // out-of-range fixed select on the 5-channel instance
    md[1] = 0; sl[1] = 3'd5; vld[1] = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_out_valid", 1, 32'(ov_o[1]), 0);
      chk("t5_in_ready", 1, 32'(rdy_o[1]), 0);
      sl[1] = 3'd7;
    end
    // reset while locked with a beat in flight
    md[1] = 1;
    tick();
    chk("t6_pre_ch", 1, 32'(och_o[1]), 4);
    chk("t6_pre_valid", 1, 32'(ov_o[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 1, 32'(ov_o[1]), 0);
    chk("t6_rst_data", 1, 32'(od_o[1]), 0);
    mreset(0); mreset(1);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk("t6_restart_ch", 1, 32'(och_o[1]), 0);
    // random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        int n = d ? 5 : 4;
        for (int k = 0; k < n; k++)
          if (!vld[d][k] || m_x[d] == k) din[d][k*16 +: 16] = 16'($urandom);
        vld[d] = 5'($urandom) & (d ? 5'b11111 : 5'b01111);
        if ($urandom_range(7) == 0) md[d] = ~md[d];
        sl[d] = d ? 3'($urandom_range(7)) : 3'($urandom_range(3));
        ordy[d] = $urandom_range(3) != 0;
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
